// File: rtl/cordic_phase_scheduler_pkg.sv
// Shared types and helpers for the CORDIC phase scheduler.
package cordic_phase_scheduler_pkg;

  localparam int unsigned ANGLE_W = 16;
  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Returns at least 1 so a pointer register always has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [MAX_CH-1:0] onehot(input logic [ID_W-1:0] id);
    return MAX_CH'(1) << id;
  endfunction

endpackage

// File: rtl/cordic_phase_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_id,
  output logic [PTR_W-1:0]  next_ptr
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = ptr;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_CH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
        next_ptr   = PTR_W'((32'(idx) + 1) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/cordic_phase_scheduler.sv
// Shares one pipelined sin/cos CORDIC core between NUM_CH requesters,
// tagging each issued angle so its result returns to the issuing channel.
module cordic_phase_scheduler
  import cordic_phase_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LATENCY = 19,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                      Clk_i,
  input  logic                      Rst_i,
  input  logic                      Enable_i,
  input  logic [NUM_CH-1:0]         Req_valid_i,
  input  logic [ANGLE_W*NUM_CH-1:0] Req_angle_i,
  output logic [NUM_CH-1:0]         Req_ready_o,
  output logic                      Cordic_valid_o,
  output logic [ANGLE_W-1:0]        Cordic_angle_o,
  input  logic [ANGLE_W-1:0]        Cordic_sin_i,
  input  logic [ANGLE_W-1:0]        Cordic_cos_i,
  output logic [NUM_CH-1:0]         Res_valid_o,
  output logic [ANGLE_W-1:0]        Res_sin_o,
  output logic [ANGLE_W-1:0]        Res_cos_o,
  output logic                      Busy_o,
  output logic [CNT_W-1:0]          Inflight_o
);

  localparam int unsigned PTR_W = clog2(NUM_CH);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, next_ptr, grant_id;
  logic [NUM_CH-1:0]  grant;
  logic               transfer;
  logic [ANGLE_W-1:0] grant_angle;
  logic [LATENCY:0]   tag_v_q;
  logic [PTR_W-1:0]   tag_id_q [LATENCY+1];
  logic [CNT_W-1:0]   inflight_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req      (Req_valid_i),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .next_ptr (next_ptr)
  );

  assign Req_ready_o = (state_q == RUN) ? grant : '0;
  assign transfer    = |Req_ready_o;
  assign grant_angle = Req_angle_i[32'(grant_id)*ANGLE_W +: ANGLE_W];
  assign Busy_o      = (state_q != IDLE) || (inflight_q != '0);
  assign Inflight_o  = inflight_q;

  // The counter still includes a tag sitting at the last stage, so a zero
  // count means the final result has already been loaded into Res_*.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Enable_i) state_d = RUN;
      RUN:     if (!Enable_i) state_d = DRAIN;
      DRAIN: begin
        if (Enable_i)               state_d = RUN;
        else if (inflight_q == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      Cordic_valid_o <= 1'b0;
      Cordic_angle_o <= '0;
      tag_v_q        <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) tag_id_q[i] <= '0;
      Res_valid_o    <= '0;
      Res_sin_o      <= '0;
      Res_cos_o      <= '0;
      inflight_q     <= '0;
    end else begin
      state_q        <= state_d;
      Cordic_valid_o <= transfer;
      if (transfer) begin
        ptr_q          <= next_ptr;
        Cordic_angle_o <= grant_angle;
      end

      tag_v_q     <= {tag_v_q[LATENCY-1:0], transfer};
      tag_id_q[0] <= grant_id;
      for (int unsigned i = 1; i <= LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];

      if (tag_v_q[LATENCY]) begin
        Res_valid_o <= NUM_CH'(onehot(ID_W'(tag_id_q[LATENCY])));
        Res_sin_o   <= Cordic_sin_i;
        Res_cos_o   <= Cordic_cos_i;
      end else begin
        Res_valid_o <= '0;
      end

      unique case ({transfer, tag_v_q[LATENCY]})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule
